decoder_rr_arbiter: RTL and testbench

// - 8-way round-robin arbiter sharing one resource among requesters 0..7.
// - Winner is held as a 3-bit index; a 3-to-8 one-hot decode of that index drives grant[0:7].
// - The decode uses the team's standard decoder convention: index bit 0 is the LSB, and out[i] = 1 iff index == i.
// - Sits between the requesting units and the shared resource.
// - Sequences ownership: grant, hold, release, rotate.
//

---
 rtl/decoder_rr_arbiter.sv | 105 ++++++++++
 tb/tb_decoder_rr_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/decoder_rr_arbiter.sv
// 8-way round-robin arbiter. The winner is kept as a 3-bit index and the
// one-hot grant vector is the registered decode of that index. Each grant
// ends on done, on withdrawal of the owner's request, or after HOLD_MAX
// cycles. A single idle cycle always separates consecutive grants.
module decoder_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned CW       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [0:7] req,
  input  logic       done,
  output logic [0:7] grant,
  output logic [0:2] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [2:0]      idx_q;
  logic [CW-1:0]   hold_cnt;
  logic [2:0]      winner;
  logic            any_req;
  logic            rel_done;
  logic            rel_drop;
  logic            rel_hold;

  // Round-robin search starting just past the last owner; the last owner
  // itself is checked last (offset 8 wraps back onto idx_q).
  always_comb begin
    winner  = idx_q;
    any_req = 1'b0;
    for (int unsigned k = 1; k <= 8; k++) begin
      logic [2:0] pos;
      pos = idx_q + 3'(k);
      if (!any_req && req[pos]) begin
        winner  = pos;
        any_req = 1'b1;
      end
    end
  end

  // Release conditions evaluated while a grant is held.
  always_comb begin
    rel_done = done;
    rel_drop = !req[idx_q];
    rel_hold = (hold_cnt == CW'(HOLD_MAX - 1));
  end

  // grant_idx is declared [0:2] with bit 0 as the LSB, so copy bit-by-bit
  // rather than assigning the whole vector (which would reverse it).
  always_comb begin
    grant_idx = '0;
    for (int unsigned b = 0; b < 3; b++) begin
      grant_idx[b] = idx_q[b];
    end
  end

  // Ownership sequencing: grant, hold, release, then one idle bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx_q       <= 3'd7;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          hold_cnt <= '0;
          if (any_req) begin
            state       <= GRANT;
            idx_q       <= winner;
            grant_valid <= 1'b1;
            for (int unsigned i = 0; i < 8; i++) begin
              grant[i] <= (winner == 3'(i));
            end
          end
        end
        GRANT: begin
          if (rel_done || rel_drop || rel_hold) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            timeout     <= rel_hold && !rel_done && !rel_drop;
          end else begin
            hold_cnt <= hold_cnt + CW'(1);
          end
        end
        default: begin
          state       <= IDLE;
          hold_cnt    <= '0;
          grant       <= '0;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Bench for decoder_rr_arbiter: directed scenarios with literal expectations
// followed by a long random stream, all checked against a cycle model.
module tb_decoder_rr_arbiter;

  localparam int HOLD_MAX = 15;

  logic       clk;
  logic       rst;
  logic [0:7] req;
  logic       done;
  logic [0:7] grant;
  logic [0:2] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  decoder_rr_arbiter #(.HOLD_MAX(HOLD_MAX), .CW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .done       (done),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int idx_val(input logic [0:2] g);
    return int'(g[0]) + 2 * int'(g[1]) + 4 * int'(g[2]);
  endfunction

  // ---------------- reference model ----------------
  bit model_ready = 0;
  bit m_valid;
  int m_idx;
  int m_held;
  bit m_timeout;
  int wait_cnt[8];
  int max_wait;

  always @(posedge clk) begin
    if (rst) begin
      model_ready = 1;
      m_valid = 0; m_idx = 7; m_held = 0; m_timeout = 0;
      for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
    end else if (model_ready) begin
      for (int i = 0; i < 8; i++) if (!req[i]) wait_cnt[i] = 0;
      if (!m_valid) begin
        m_timeout = 0;
        if (req != 8'h00) begin
          int w;
          w = -1;
          for (int k = 1; k <= 8; k++)
            if (w < 0 && req[(m_idx + k) % 8]) w = (m_idx + k) % 8;
          for (int i = 0; i < 8; i++)
            if (i == w) wait_cnt[i] = 0;
            else if (req[i]) wait_cnt[i]++;
          m_valid = 1; m_idx = w; m_held = 1;
        end
      end else begin
        bit a, b, c;
        a = done; b = !req[m_idx]; c = (m_held == HOLD_MAX);
        if (a || b || c) begin
          m_valid = 0; m_timeout = c && !a && !b; m_held = 0;
        end else begin
          m_held++; m_timeout = 0;
        end
      end
      max_wait = 0;
      for (int i = 0; i < 8; i++) if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_ready) begin
      logic [0:7] eg;
      int pc;
      for (int i = 0; i < 8; i++) eg[i] = m_valid && (m_idx == i);
      check("model_grant", int'(grant), int'(eg));
      check("model_idx", idx_val(grant_idx), m_idx);
      check("model_valid", int'(grant_valid), int'(m_valid));
      check("model_timeout", int'(timeout), int'(m_timeout));
      pc = $countones(grant);
      check("inv_onehot", int'(pc <= 1), 1);
      check("inv_valid_or", int'(grant_valid), int'(|grant));
      if (grant_valid) check("inv_idx_bit", int'(grant[idx_val(grant_idx)]), 1);
      check("fairness", int'(max_wait <= 8), 1);
    end
  end

  // ---------------- directed + random stimulus ----------------
  int n;
  initial begin
    rst = 1; req = '0; done = 0;
    repeat (2) @(negedge clk);
    check("rst_grant", int'(grant), 0);
    check("rst_idx", idx_val(grant_idx), 7);
    check("rst_valid", int'(grant_valid), 0);
    check("rst_timeout", int'(timeout), 0);
    rst = 0;

    // requesters 0 and 7, no done: 0 holds HOLD_MAX cycles, then 7
    req = 8'b1000_0001;
    @(negedge clk);
    check("t2_first_grant", int'(grant), 8'h80);
    n = 1;
    while (grant_valid && n < 40) begin @(negedge clk); if (grant_valid) n++; end
    check("t2_hold_len", n, HOLD_MAX);
    check("t2_timeout", int'(timeout), 1);
    @(negedge clk);
    check("t2_timeout_gone", int'(timeout), 0);
    check("t2_second_grant", int'(grant), 8'h01);
    check("t2_second_idx", idx_val(grant_idx), 7);
    req = '0;
    @(negedge clk);
    check("t2_withdraw_valid", int'(grant_valid), 0);
    check("t2_withdraw_timeout", int'(timeout), 0);

    // all requesting, done held: order 0..7,0 with one bubble each
    req = 8'hFF; done = 1;
    for (int k = 0; k < 9; k++) begin
      int m;
      @(negedge clk);
      m = 1;
      while (!grant_valid && m < 6) begin @(negedge clk); m++; end
      check("t3_order", idx_val(grant_idx), k % 8);
      check("t3_gap", m, (k == 0) ? 1 : 2);
    end
    done = 0; req = '0;
    @(negedge clk);

    // owner 3 withdraws on its cycle 2; next search starts at 4
    req = 8'b0001_0000;
    n = 0;
    while (!grant_valid && n < 6) begin @(negedge clk); n++; end
    check("t4_owner", idx_val(grant_idx), 3);
    repeat (2) @(negedge clk);
    req = 8'b0100_0100;
    @(negedge clk);
    check("t4_release", int'(grant_valid), 0);
    check("t4_timeout", int'(timeout), 0);
    @(negedge clk);
    check("t4_next_owner", idx_val(grant_idx), 5);

    // done coincides with the final hold cycle: no timeout
    repeat (HOLD_MAX - 1) @(negedge clk);
    check("t5_still_held", int'(grant_valid), 1);
    done = 1;
    @(negedge clk);
    check("t5_release", int'(grant_valid), 0);
    check("t5_timeout", int'(timeout), 0);

    // reset while owner 5 holds
    req = 8'hFF;
    n = 0;
    while (!(grant_valid && idx_val(grant_idx) == 5) && n < 60) begin @(negedge clk); n++; end
    check("t6_reach_owner5", int'(grant_valid && idx_val(grant_idx) == 5), 1);
    rst = 1; done = 0;
    @(negedge clk);
    check("t6_rst_grant", int'(grant), 0);
    check("t6_rst_idx", idx_val(grant_idx), 7);
    rst = 0;
    @(negedge clk);
    check("t6_after_rst", int'(grant), 8'h80);

    // random stream
    for (int c = 0; c < 10000; c++) begin
      req  = req ^ 8'($urandom & $urandom & $urandom);
      done = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 999) == 0);
      @(negedge clk);
    end
    rst = 0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
